// File: rtl/gt_share_arbiter_if.sv
// Request/operand/grant/response bundle between client blocks and gt_share_arbiter.
// rsp_eq only exists when GT_EQ_FLAG_EN is defined.
interface gt_share_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 2
);
    localparam int ID_W = $clog2(NREQ);

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] opa;
    logic [NREQ*WIDTH-1:0] opb;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic                  rsp_gt;
`ifdef GT_EQ_FLAG_EN
    logic                  rsp_eq;
`endif

    modport master (
        output req, opa, opb, rsp_ready,
        input  gnt, busy, rsp_valid, rsp_id, rsp_gt
`ifdef GT_EQ_FLAG_EN
        , input rsp_eq
`endif
    );

    modport slave (
        input  req, opa, opb, rsp_ready,
        output gnt, busy, rsp_valid, rsp_id, rsp_gt
`ifdef GT_EQ_FLAG_EN
        , output rsp_eq
`endif
    );
endinterface

// File: rtl/gt_share_arbiter.sv
// Round-robin arbiter sharing one unsigned A>B comparator among NREQ requesters.
// Optional equality flag (rsp_eq) is built when GT_EQ_FLAG_EN is defined.
module gt_share_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    gt_share_arbiter_if.slave  bus
);
    localparam int ID_W = $clog2(NREQ);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMP  = 2'd1;
    localparam logic [1:0] ST_RSP  = 2'd2;

    logic [1:0]       state_reg;
    logic [ID_W-1:0]  rr_ptr_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [NREQ-1:0]  gnt_reg;
    logic             rsp_valid_reg;
    logic [ID_W-1:0]  rsp_id_reg;
    logic             rsp_gt_reg;
`ifdef GT_EQ_FLAG_EN
    logic             rsp_eq_reg;
`endif

    logic [WIDTH-1:0] opa_arr [NREQ];
    logic [WIDTH-1:0] opb_arr [NREQ];
    logic [NREQ-1:0]  gnt_next;
    logic [ID_W-1:0]  winner_next;
    logic [ID_W-1:0]  cand_next;
    logic             found_next;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
            assign opa_arr[gi]  = bus.opa[gi*WIDTH +: WIDTH];
            assign opb_arr[gi]  = bus.opb[gi*WIDTH +: WIDTH];
            assign gnt_next[gi] = (winner_next == ID_W'(gi));
        end
    endgenerate

    // Search starts one past the last winner, so the previous winner is checked last.
    always_comb begin
        found_next  = 1'b0;
        winner_next = '0;
        cand_next   = rr_ptr_reg;
        for (int k = 0; k < NREQ; k++) begin
            cand_next = (cand_next == ID_W'(NREQ-1)) ? '0 : cand_next + ID_W'(1);
            if (!found_next && bus.req[cand_next]) begin
                found_next  = 1'b1;
                winner_next = cand_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            rr_ptr_reg    <= ID_W'(NREQ-1);
            a_reg         <= '0;
            b_reg         <= '0;
            gnt_reg       <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= '0;
            rsp_gt_reg    <= 1'b0;
`ifdef GT_EQ_FLAG_EN
            rsp_eq_reg    <= 1'b0;
`endif
        end else begin
            gnt_reg <= '0;
            case (state_reg)
                ST_IDLE: begin
                    if (found_next) begin
                        a_reg      <= opa_arr[winner_next];
                        b_reg      <= opb_arr[winner_next];
                        gnt_reg    <= gnt_next;
                        rr_ptr_reg <= winner_next;
                        state_reg  <= ST_CMP;
                    end
                end
                ST_CMP: begin
                    // rr_ptr_reg still holds the winner latched in IDLE.
                    rsp_gt_reg    <= (a_reg > b_reg);
`ifdef GT_EQ_FLAG_EN
                    rsp_eq_reg    <= (a_reg == b_reg);
`endif
                    rsp_id_reg    <= rr_ptr_reg;
                    rsp_valid_reg <= 1'b1;
                    state_reg     <= ST_RSP;
                end
                ST_RSP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.gnt       = gnt_reg;
    assign bus.busy      = (state_reg != ST_IDLE);
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_id    = rsp_id_reg;
    assign bus.rsp_gt    = rsp_gt_reg;
`ifdef GT_EQ_FLAG_EN
    assign bus.rsp_eq    = rsp_eq_reg;
`endif
endmodule

// File: tb/tb_gt_share_arbiter.sv
// Scoreboard bench for gt_share_arbiter: driver runs a transaction-level model and
// queues expected responses; a negedge monitor compares DUT outputs against it.
module tb_gt_share_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 2;
    localparam int ID_W  = $clog2(NREQ);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    gt_share_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    gt_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        bit gt;
        bit eq;
    } rsp_t;

    rsp_t exp_q[$];

    int tests = 0;
    int fails = 0;

    // Model: 0 = free, 1 = comparing, 2 = response offered
    int              phase         = 0;
    int              next_phase    = 0;
    int              last_winner   = NREQ - 1;
    bit              grant_pending = 1'b0;
    int              pend_id       = 0;
    logic [NREQ-1:0] exp_gnt       = '0;
    bit              granted_now   = 1'b0;
    bit              hold_rst      = 1'b1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model decides what the DUT must do at the next edge.
    task automatic step(input logic [NREQ-1:0] r, input logic [NREQ*WIDTH-1:0] a,
                        input logic [NREQ*WIDTH-1:0] b, input bit rdy);
        logic [WIDTH-1:0] av;
        logic [WIDTH-1:0] bv;
        int               w;
        bit               found;
        @(posedge clk);
        #1;
        rst_n = hold_rst ? 1'b0 : 1'b1;
        if (!rst_n) begin
            phase = 0; next_phase = 0; grant_pending = 0;
            exp_gnt = '0; last_winner = NREQ - 1;
            exp_q.delete();
        end else begin
            exp_gnt = grant_pending ? (NREQ'(1) << pend_id) : '0;
            grant_pending = 0;
            phase = next_phase;
        end
        bus.req = r; bus.opa = a; bus.opb = b; bus.rsp_ready = rdy;
        granted_now = 0;
        if (rst_n) begin
            if (phase == 0 && r != 0) begin
                found = 0; w = 0;
                for (int k = 1; k <= NREQ; k++) begin
                    if (!found && r[(last_winner + k) % NREQ]) begin
                        found = 1;
                        w = (last_winner + k) % NREQ;
                    end
                end
                av = a[w*WIDTH +: WIDTH];
                bv = b[w*WIDTH +: WIDTH];
                exp_q.push_back('{w, av > bv, av == bv});
                $display("[TB] grant req=%b -> id %0d  A=%0d B=%0d", r, w, av, bv);
                last_winner = w; pend_id = w; grant_pending = 1;
                granted_now = 1; next_phase = 1;
            end else if (phase == 1) begin
                next_phase = 2;
            end else if (phase == 2 && rdy) begin
                next_phase = 0;
            end
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        chk("gnt", int'(bus.gnt), int'(exp_gnt));
        chk("busy", int'(bus.busy), int'(phase != 0));
        chk("rsp_valid", int'(bus.rsp_valid), int'(phase == 2));
        if (!rst_n) begin
            chk("rst_rsp_id", int'(bus.rsp_id), 0);
            chk("rst_rsp_gt", int'(bus.rsp_gt), 0);
`ifdef GT_EQ_FLAG_EN
            chk("rst_rsp_eq", int'(bus.rsp_eq), 0);
`endif
        end
        if (bus.rsp_valid && phase == 2) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 1, 0);
            end else begin
                chk("rsp_id", int'(bus.rsp_id), exp_q[0].id);
                chk("rsp_gt", int'(bus.rsp_gt), int'(exp_q[0].gt));
`ifdef GT_EQ_FLAG_EN
                chk("rsp_eq", int'(bus.rsp_eq), int'(exp_q[0].eq));
`endif
                if (bus.rsp_ready) begin
                    $display("[TB] response id=%0d gt=%0d accepted", bus.rsp_id, bus.rsp_gt);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NREQ*WIDTH-1:0] va;
        logic [NREQ*WIDTH-1:0] vb;
        int order[$];
        int guard;
        bus.req = '0; bus.opa = '0; bus.opb = '0; bus.rsp_ready = 1'b0;
        hold_rst = 1;
        repeat (3) step('0, '0, '0, 1'b1);
        hold_rst = 0;

        // Single request: A0=3, B0=1
        va = '0; vb = '0;
        va[0 +: WIDTH] = WIDTH'(3); vb[0 +: WIDTH] = WIDTH'(1);
        step(NREQ'(1), va, vb, 1'b1);
        repeat (5) step('0, va, vb, 1'b1);

        // Full sweep of requester 2; operands change right after each grant
        for (int i = 0; i < 16; i++) begin
            va = '0; vb = '0;
            va[2*WIDTH +: WIDTH] = WIDTH'(i >> 2);
            vb[2*WIDTH +: WIDTH] = WIDTH'(i & 3);
            guard = 0;
            do begin
                step(NREQ'(4), va, vb, 1'b1);
                guard++;
            end while (!granted_now && guard < 10);
            chk("sweep_granted", int'(granted_now), 1);
        end
        repeat (4) step('0, '0, '0, 1'b1);

        // Round-robin from reset with all requests held
        hold_rst = 1; step('0, '0, '0, 1'b1); hold_rst = 0;
        for (int i = 0; i < 18; i++) begin
            step('1, $urandom(), $urandom(), 1'b1);
            if (granted_now) order.push_back(pend_id);
        end
        chk("rr_count", order.size(), 6);
        for (int i = 0; i < 6 && i < order.size(); i++)
            chk("rr_order", order[i], i % NREQ);

        // Backpressure: response held for several cycles, others keep requesting
        repeat (4) step('0, '0, '0, 1'b1);
        step(NREQ'(1), $urandom(), $urandom(), 1'b0);
        repeat (7) step('1, $urandom(), $urandom(), 1'b0);
        repeat (6) step('0, '0, '0, 1'b1);

        // Operand change after grant: A1=1, B1=2 then A1=3
        va = '0; vb = '0;
        va[WIDTH +: WIDTH] = WIDTH'(1); vb[WIDTH +: WIDTH] = WIDTH'(2);
        step(NREQ'(2), va, vb, 1'b1);
        va[WIDTH +: WIDTH] = WIDTH'(3);
        repeat (4) step('0, va, vb, 1'b1);

        // Reset during CMP, then req=1010 must pick requester 1
        step('1, $urandom(), $urandom(), 1'b1);
        hold_rst = 1;
        step('0, '0, '0, 1'b1);
        step('0, '0, '0, 1'b1);
        hold_rst = 0;
        step(NREQ'(4'b1010), $urandom(), $urandom(), 1'b1);
        chk("rst_granted", int'(granted_now), 1);
        chk("rst_first_id", pend_id, 1);
        repeat (4) step('0, '0, '0, 1'b1);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 2) == 0) ? '0 : NREQ'($urandom()),
                 $urandom(), $urandom(), $urandom_range(0, 3) != 0);
        end

        repeat (6) step('0, '0, '0, 1'b1);
        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
